// File: rtl/mem_addr_seq.sv
// Memory address sequencer. It loads mem_addr from one of NSRC sources, or it fetches
// an exception vector byte through a small IDLE/WAIT/DONE handshake.
module mem_addr_seq #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NSRC     = 6,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned VEC_NOOP = 253,
  parameter int unsigned VEC_OVF  = 254,
  parameter int unsigned VEC_DIV0 = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NSRC)-1:0]  sel,
  input  logic [NSRC*WIDTH-1:0]    src_flat,
  input  logic                     addr_load,
  input  logic [1:0]               exc_code,
  input  logic [7:0]               mem_rdata,
  output logic [WIDTH-1:0]         mem_addr,
  output logic                     exc_busy,
  output logic                     exc_done,
  output logic [WIDTH-1:0]         exc_target,
  output logic                     sel_err
);

  localparam int unsigned SelW = $clog2(NSRC);
  localparam int unsigned CntW = $clog2(MEM_LAT) + 1;
  // One extra bit lets NSRC be compared against sel when NSRC is a power of two.
  localparam logic [SelW:0] NsrcW = (SelW + 1)'(NSRC);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]  tgt_q, tgt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              sel_ok;
  logic [WIDTH-1:0]  sel_src;
  logic [WIDTH-1:0]  vec_addr;

  assign sel_ok = ({1'b0, sel} < NsrcW);

  always_comb begin
    sel_src = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SelW'(i)) sel_src = src_flat[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    vec_addr = '0;
    unique case (exc_code)
      2'b01:   vec_addr = WIDTH'(VEC_NOOP);
      2'b10:   vec_addr = WIDTH'(VEC_OVF);
      2'b11:   vec_addr = WIDTH'(VEC_DIV0);
      default: vec_addr = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // An exception takes priority. Any load in the same cycle is dropped silently.
        if (exc_code != 2'b00) begin
          addr_d  = vec_addr;
          cnt_d   = CntW'(MEM_LAT - 1);
          state_d = StWait;
        end else if (addr_load) begin
          if (sel_ok) addr_d = sel_src;
          else        err_d  = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          tgt_d   = {{(WIDTH-8){1'b0}}, mem_rdata};
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr   = addr_q;
  assign exc_target = tgt_q;
  assign sel_err    = err_q;
  assign exc_busy   = (state_q != StIdle);
  assign exc_done   = (state_q == StDone);

endmodule
